// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one single-port SRAM between an instruction master (i_*) and a data
// master (d_*). At most one access is issued per cycle, chosen round-robin
// when both masters request. Reads return RD_LAT cycles after their grant and
// are steered back to the issuing master by a tag shift register.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_req/i_we/i_addr/i_wdata/i_be   instruction master request
//   i_gnt, i_rvalid, i_rdata         instruction master grant / read return
//   d_req/d_we/d_addr/d_wdata/d_be   data master request
//   d_gnt, d_rvalid, d_rdata         data master grant / read return
//   m_en/m_we/m_addr/m_wdata/m_be    SRAM command
//   m_rdata                          SRAM read data (valid RD_LAT after m_en)
module mem_bus_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int DATA_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW/8-1:0]   i_be,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_be,
    input  logic [DW-1:0]     m_rdata
);

    logic              r_last_d;      // 1: most recent grant went to the data master
    logic [AW-1:0]     r_addr;        // last issued address, held while idle
    logic [DW-1:0]     r_wdata;       // last issued write data, held while idle
    logic [RD_LAT-1:0] r_tag_vld;     // read-in-flight flag per pipeline slot
    logic [RD_LAT-1:0] r_tag_own;     // owner per slot: 1 = data master
    logic [DW-1:0]     r_i_rdata;
    logic [DW-1:0]     r_d_rdata;

    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_en;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_wdata;
    logic [DW/8-1:0]   w_be;
    logic              w_i_rv;
    logic              w_d_rv;

    // Grant decision. Gated by rst so nothing is granted while reset is held.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (rst) begin
            if (i_req && d_req) begin
                w_gnt_d = !r_last_d;
                w_gnt_i = r_last_d;
            end else begin
                w_gnt_i = i_req;
                w_gnt_d = d_req;
            end
        end
    end

    assign w_en    = w_gnt_i | w_gnt_d;
    assign w_we    = w_gnt_d ? d_we    : i_we;
    assign w_addr  = w_gnt_d ? d_addr  : i_addr;
    assign w_wdata = w_gnt_d ? d_wdata : i_wdata;
    assign w_be    = w_gnt_d ? d_be    : i_be;

    assign i_gnt   = w_gnt_i;
    assign d_gnt   = w_gnt_d;
    assign m_en    = w_en;
    assign m_we    = w_en & w_we;
    assign m_be    = w_en ? w_be : '0;
    assign m_addr  = w_en ? w_addr  : r_addr;
    assign m_wdata = w_en ? w_wdata : r_wdata;

    // Reset leaves the "last grant" on the instruction side when the data
    // master should win the first tie, and vice versa.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= (DATA_FIRST != 0) ? 1'b0 : 1'b1;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_en) begin
            r_last_d <= w_gnt_d;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
        end
    end

    // Tag pipeline: slot 0 is loaded on the grant edge, slot RD_LAT-1 lines up
    // with the cycle the SRAM presents the read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld[0] <= w_en & ~w_we;
            r_tag_own[0] <= w_gnt_d;
            for (int k = 1; k < RD_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_own[k] <= r_tag_own[k-1];
            end
        end
    end

    assign w_i_rv = r_tag_vld[RD_LAT-1] & ~r_tag_own[RD_LAT-1];
    assign w_d_rv = r_tag_vld[RD_LAT-1] &  r_tag_own[RD_LAT-1];

    // Read data passes straight through on the return cycle and is captured so
    // each master's rdata holds its last returned word otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_i_rv) r_i_rdata <= m_rdata;
            if (w_d_rv) r_d_rdata <= m_rdata;
        end
    end

    assign i_rvalid = w_i_rv;
    assign d_rvalid = w_d_rv;
    assign i_rdata  = w_i_rv ? m_rdata : r_i_rdata;
    assign d_rdata  = w_d_rv ? m_rdata : r_d_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: four instances (RD_LAT = 1..4) share the same
// master stimulus, each with its own behavioural SRAM, and are checked against
// a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int NL = 4;
    localparam int NC = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, i_we, d_req, d_we;
    logic [11:0] i_addr, d_addr;
    logic [31:0] i_wdata, d_wdata;
    logic [3:0]  i_be, d_be;

    logic [NL-1:0] a_ig, a_dg, a_irv, a_drv, a_en, a_we;
    logic [11:0]   a_addr [NL];
    logic [31:0]   a_wd   [NL];
    logic [31:0]   a_ird  [NL];
    logic [31:0]   a_drd  [NL];
    logic [31:0]   a_mrd  [NL];
    logic [3:0]    a_be   [NL];

    function automatic logic [31:0] init_word(input int a);
        logic [11:0] w;
        w = 12'(a);
        return {4'hA, w, 4'h5, ~w};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : gl
        logic [31:0] mem [0:4095];
        logic [31:0] rp  [0:g];

        mem_bus_arbiter #(.AW(12), .DW(32), .RD_LAT(g + 1), .DATA_FIRST(1)) u_dut (
            .clk(clk), .rst(rst),
            .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_be(i_be),
            .i_gnt(a_ig[g]), .i_rvalid(a_irv[g]), .i_rdata(a_ird[g]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
            .d_gnt(a_dg[g]), .d_rvalid(a_drv[g]), .d_rdata(a_drd[g]),
            .m_en(a_en[g]), .m_we(a_we[g]), .m_addr(a_addr[g]), .m_wdata(a_wd[g]),
            .m_be(a_be[g]), .m_rdata(a_mrd[g])
        );

        initial for (int a = 0; a < 4096; a++) mem[a] = init_word(a);

        always @(posedge clk) begin
            if (a_en[g]) begin
                if (a_we[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (a_be[g][b]) mem[a_addr[g]][8*b +: 8] <= a_wd[g][8*b +: 8];
                end else begin
                    rp[0] <= mem[a_addr[g]];
                end
            end
            for (int k = 1; k <= g; k++) rp[k] <= rp[k-1];
        end
        assign a_mrd[g] = rp[g];
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int          cyc = 0;
    logic [31:0] ref_mem [4096];
    bit          pref_d;            // master that wins the next tie: 1 = data
    logic [11:0] last_addr;
    logic [31:0] last_wd;
    bit          ev_i [NL][NC];
    bit          ev_d [NL][NC];
    logic [31:0] edat [NL][NC];
    logic [31:0] hold_i [NL];
    logic [31:0] hold_d [NL];
    bit          g_i, g_d;

    task automatic model_reset();
        pref_d    = 1'b1;
        last_addr = '0;
        last_wd   = '0;
        for (int k = 0; k < NL; k++) begin
            hold_i[k] = '0;
            hold_d[k] = '0;
            for (int c = cyc; c < cyc + NL + 2; c++) begin
                ev_i[k][c] = 1'b0;
                ev_d[k][c] = 1'b0;
            end
        end
    endtask

    task automatic model_check();
        bit          en, we;
        logic [11:0] ad;
        logic [31:0] wd;
        logic [3:0]  be;
        g_i = 1'b0;
        g_d = 1'b0;
        if (i_req && d_req) begin
            if (pref_d) g_d = 1'b1; else g_i = 1'b1;
        end else if (i_req) g_i = 1'b1;
        else if (d_req) g_d = 1'b1;
        en = g_i || g_d;
        we = 1'b0; be = '0; ad = last_addr; wd = last_wd;
        if (g_d) begin we = d_we; be = d_be; ad = d_addr; wd = d_wdata; end
        if (g_i) begin we = i_we; be = i_be; ad = i_addr; wd = i_wdata; end

        check_eq("i_gnt", 32'(a_ig[0]), 32'(g_i));
        check_eq("d_gnt", 32'(a_dg[0]), 32'(g_d));
        check_eq("gnt_all_inst", {28'h0, a_ig}, {28'h0, {NL{g_i}}});
        check_eq("m_en", 32'(a_en[0]), 32'(en));
        check_eq("m_we", 32'(a_we[0]), 32'(en && we));
        check_eq("m_be", 32'(a_be[0]), en ? 32'(be) : 32'h0);
        check_eq("m_addr", 32'(a_addr[0]), 32'(ad));
        check_eq("m_wdata", a_wd[0], wd);

        for (int k = 0; k < NL; k++) begin
            if (ev_i[k][cyc]) hold_i[k] = edat[k][cyc];
            if (ev_d[k][cyc]) hold_d[k] = edat[k][cyc];
            check_eq($sformatf("i_rvalid_L%0d", k + 1), 32'(a_irv[k]), 32'(ev_i[k][cyc]));
            check_eq($sformatf("d_rvalid_L%0d", k + 1), 32'(a_drv[k]), 32'(ev_d[k][cyc]));
            check_eq($sformatf("i_rdata_L%0d", k + 1), a_ird[k], hold_i[k]);
            check_eq($sformatf("d_rdata_L%0d", k + 1), a_drd[k], hold_d[k]);
        end

        if (en) begin
            last_addr = ad;
            last_wd   = wd;
            pref_d    = g_i;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[ad][8*b +: 8] = wd[8*b +: 8];
            end else begin
                for (int k = 0; k < NL; k++) begin
                    ev_i[k][cyc + k + 1] = g_i;
                    ev_d[k][cyc + k + 1] = g_d;
                    edat[k][cyc + k + 1] = ref_mem[ad];
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic reset_zero_check(input string tag);
        check_eq({tag, "_gnt"}, {24'h0, a_ig, a_dg}, 32'h0);
        check_eq({tag, "_en_we"}, {24'h0, a_en, a_we}, 32'h0);
        check_eq({tag, "_rvalid"}, {24'h0, a_irv, a_drv}, 32'h0);
        check_eq({tag, "_m_addr"}, 32'(a_addr[0]), 32'h0);
        check_eq({tag, "_m_wdata"}, a_wd[0], 32'h0);
        check_eq({tag, "_m_be"}, 32'(a_be[0]), 32'h0);
        for (int k = 0; k < NL; k++) begin
            check_eq($sformatf("%s_i_rdata_L%0d", tag, k + 1), a_ird[k], 32'h0);
            check_eq($sformatf("%s_d_rdata_L%0d", tag, k + 1), a_drd[k], 32'h0);
        end
    endtask

    task automatic set_i(input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] dat, input logic [3:0] b);
        i_req = r; i_we = w; i_addr = a; i_wdata = dat; i_be = b;
    endtask

    task automatic set_d(input logic r, input logic w, input logic [11:0] a,
                         input logic [31:0] dat, input logic [3:0] b);
        d_req = r; d_we = w; d_addr = a; d_wdata = dat; d_be = b;
    endtask

    task automatic idle(input int n);
        set_i(0, 0, 12'h0, 32'h0, 4'h0);
        set_d(0, 0, 12'h0, 32'h0, 4'h0);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ni, nd;
        for (int a = 0; a < 4096; a++) ref_mem[a] = init_word(a);
        rst = 1'b0;
        set_i(1, 0, 12'h001, 32'h0, 4'hF);
        set_d(1, 0, 12'h002, 32'h0, 4'hF);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_zero_check("por");
        set_i(0, 0, 12'h0, 32'h0, 4'h0);
        set_d(0, 0, 12'h0, 32'h0, 4'h0);
        rst = 1'b1;

        // Instruction-only reads of words 0..3
        for (int n = 0; n < 4; n++) begin
            set_i(1, 0, 12'(n), 32'h0, 4'hF);
            tick();
        end
        idle(5);

        // Both masters reading continuously: D first, then strict alternation
        ni = 0; nd = 0;
        for (int n = 0; n < 6; n++) begin
            set_i(1, 0, 12'(12'h100 + ni), 32'h0, 4'hF);
            set_d(1, 0, 12'(12'h200 + nd), 32'h0, 4'hF);
            tick();
            if (g_i) ni++;
            if (g_d) nd++;
        end
        idle(5);

        // Data write then instruction read of the same word on the next cycle
        set_d(1, 1, 12'h010, 32'hDEADBEEF, 4'hF);
        tick();
        set_d(0, 0, 12'h0, 32'h0, 4'h0);
        set_i(1, 0, 12'h010, 32'h0, 4'hF);
        tick();
        idle(5);

        // Partial byte-enable write merges into the existing word
        set_d(1, 1, 12'h020, 32'h11223344, 4'hF);
        tick();
        set_d(1, 1, 12'h020, 32'h0000AB00, 4'h2);
        tick();
        set_d(0, 0, 12'h0, 32'h0, 4'h0);
        set_i(1, 0, 12'h020, 32'h0, 4'hF);
        tick();
        idle(5);

        // Reset one cycle after a granted read: in-flight returns are dropped
        set_i(1, 0, 12'h005, 32'h0, 4'hF);
        tick();
        set_i(1, 0, 12'h006, 32'h0, 4'hF);
        rst = 1'b0;
        #1;
        reset_zero_check("midrst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(6);

        // Continuous reads from both masters: a grant every cycle
        for (int n = 0; n < 40; n++) begin
            if (n == 0 || g_i) set_i(1, 0, 12'($urandom_range(0, 4095)), 32'h0, 4'hF);
            if (n == 0 || g_d) set_d(1, 0, 12'($urandom_range(0, 4095)), 32'h0, 4'hF);
            tick();
        end
        idle(5);

        // Random traffic on a small address window to provoke RAW collisions
        for (int n = 0; n < 600; n++) begin
            if (!i_req || g_i)
                set_i($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                      12'($urandom_range(0, 31)), $urandom, 4'($urandom_range(1, 15)));
            if (!d_req || g_d)
                set_d($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 0,
                      12'($urandom_range(0, 31)), $urandom, 4'($urandom_range(1, 15)));
            tick();
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter that shares one single-port 4K x 32 SRAM between the core's instruction port and data port.
- Sits between the akarin_riscv core's two memory requesters and the sram_4kx32 instance, so a unified memory can hold both code and data.
- Round-robin arbitration: at most one access per cycle, fully pipelined, with a read-data return path tagged back to the issuing master.

Parameters:
- AW, 12, word address width (4K words).
- DW, 32, data width.
- RD_LAT, 1, SRAM read latency in cycles from m_en to m_rdata valid; legal 1..4.
- DATA_FIRST, 1, which master wins the first tie after reset: 1 = data port, 0 = instruction port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction port request.
- i_we  in  1  instruction port write enable (normally 0).
- i_addr  in  AW  instruction port word address.
- i_wdata  in  DW  instruction port write data.
- i_be  in  DW/8  instruction port byte enables.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  instruction read data valid.
- i_rdata  out  DW  instruction read data.
- d_req, d_we, d_addr, d_wdata, d_be  in  1/1/AW/DW/DW/8  data port request, same meaning as the i_ signals.
- d_gnt, d_rvalid, d_rdata  out  1/1/DW  data port responses, same meaning as the i_ signals.
- m_en  out  1  SRAM access strobe.
- m_we  out  1  SRAM write enable.
- m_addr  out  AW  SRAM address.
- m_wdata  out  DW  SRAM write data.
- m_be  out  DW/8  SRAM byte enables.
- m_rdata  in  DW  SRAM read data.

Behaviour:
- Reset (rst=0, async):
  - last_grant register set so the DATA_FIRST master wins the next tie.
  - Read tag pipeline cleared.
  - i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we = 0; m_addr, m_wdata, m_be, i_rdata, d_rdata = 0.
- Grant decision is combinational in the cycle of request:
  - Only one requester: it is granted.
  - Both requesting: the master not granted last is granted.
  - last_grant updates on the clock edge only when a grant occurs; idle cycles do not change it.
- A request is consumed on a cycle with gnt=1.
  - A master seeing req=1 and gnt=0 must hold req, we, addr, wdata and be stable until granted.
  - The arbiter never grants a deasserted req.
- m_en = i_gnt | d_gnt. m_we, m_addr, m_wdata and m_be are muxed from the granted master.
- When m_en=0, m_we = 0 and m_be = 0. m_addr and m_wdata hold their last value (don't-care to the SRAM).
- Read return:
  - A granted read (we=0) pushes a tag {valid=1, owner} into an RD_LAT-deep shift register; writes push valid=0.
  - When a tag reaches the pipeline output, the owner's rvalid is pulsed for one cycle, exactly RD_LAT cycles after its gnt, and its rdata is driven with m_rdata.
  - The non-owner's rvalid stays 0 and its rdata holds its previous value.
- Throughput: back-to-back grants every cycle with no bubbles. Responses return in grant order. Both rvalid are never high in the same cycle.
- Writes: no response; complete on the grant cycle.
- Simultaneous events:
  - A grant and a return in the same cycle are independent.
  - A read to an address that was written in the previous cycle returns the new data; the SRAM provides this, and the arbiter reorders nothing.
- Reset mid-operation: in-flight tags are discarded and no rvalid fires after reset deasserts for pre-reset reads.
- Starvation bound: with both masters requesting continuously, grants strictly alternate I, D, I, D...; neither waits more than 1 cycle.

Test Plan:
- Reset, then only i_req=1 with addr=0x000..0x003 for 4 cycles -> i_gnt=1 each cycle, m_addr=0..3, i_rvalid pulses on cycles 2..5 with the preloaded words; d_gnt and d_rvalid stay 0.
- After reset, i_req=d_req=1 held for 6 cycles (DATA_FIRST=1) -> grant order D,I,D,I,D,I; each rvalid goes to the correct owner RD_LAT later; no cycle has both gnt high.
- D write to addr 0x010, data 0xDEADBEEF, be=0xF, then the next cycle I read of 0x010 -> m_we=1 on the first cycle, i_rdata=0xDEADBEEF on the rvalid cycle; no d_rvalid for the write.
- Byte-enable write: be=0x2, data 0x0000AB00 to a word holding 0x11223344 -> a later read returns 0x1122AB44.
- Assert rst=0 one cycle after a granted read -> outputs go to 0 immediately (async); after release, no stale rvalid appears.
- Parameter sweep RD_LAT=1..4 with continuous alternating reads -> rvalid exactly RD_LAT cycles after each gnt, 100% bus utilisation.
